// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per request, LSB first, framed by a start
// bit (0) and a stop bit (1), with a one-cycle completion pulse.
module uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_send,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      idx     <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_send) begin
            shreg   <= tx_data;
            cnt     <= '0;
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (wrap) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (wrap) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            idx   <= idx + 3'd1;
            // tx is registered, so the next bit is taken from shreg[1] now
            if (idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (wrap) begin
            cnt     <= '0;
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit (40-cycle frame).
// Label n = the clock cycle following the (n-1)th edge after accept edge T0.
module tb_uart_tx;

  logic       clock;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic       tx_done;
  logic       tx;

  uart_tx #(.CLK_FREQ(1000), .BAUD(250)) dut (
    .clock   (clock),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_send (tx_send),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = i-th bit on the line, start bit first
    int         lows;   // cycles with tx=0 in the frame
  } vec_t;

  vec_t vecs[5];
  logic tx_log   [0:127];
  logic busy_log [0:127];
  logic done_log [0:127];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string nm, input int lbl, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lbl=%0d got=%b want=%b", nm, lbl, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Steps n labels after the accept edge, logging outputs; optional event
  // at ev_lbl rewrites tx_data/tx_send, and tx_send drops at off_lbl.
  task automatic capture(input int n, input int ev_lbl, input logic [7:0] ev_data,
                         input logic ev_send, input logic ev_pulse, input int off_lbl);
    for (int l = 1; l <= n; l++) begin
      step();
      tx_log[l]   = tx;
      busy_log[l] = tx_busy;
      done_log[l] = tx_done;
      if (l == off_lbl) tx_send = 1'b0;
      if (l == ev_lbl) begin
        tx_data = ev_data;
        tx_send = ev_send;
      end
      if (ev_pulse && l == ev_lbl + 1) tx_send = 1'b0;
    end
  endtask

  task automatic check_frame(input int base, input logic [9:0] exp, input string nm);
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 4; c++) begin
        chk({nm, "_tx"},   base + 4*b + c, tx_log[base + 4*b + c],   exp[b]);
        chk({nm, "_busy"}, base + 4*b + c, busy_log[base + 4*b + c], 1'b1);
        chk({nm, "_done"}, base + 4*b + c, done_log[base + 4*b + c], 1'b0);
      end
    chk({nm, "_end_done"}, base + 40, done_log[base + 40], 1'b1);
    chk({nm, "_end_busy"}, base + 40, busy_log[base + 40], 1'b0);
    chk({nm, "_end_tx"},   base + 40, tx_log[base + 40],   1'b1);
  endtask

  initial begin
    int lows;
    int dones;
    vecs[0] = '{8'hA5, 10'b1101001010, 20};
    vecs[1] = '{8'hFF, 10'b1111111110, 4};
    vecs[2] = '{8'h00, 10'b1000000000, 36};
    vecs[3] = '{8'h81, 10'b1100000010, 28};
    vecs[4] = '{8'h3C, 10'b1001111000, 20};

    // Reset held with a pending request: line idle, nothing starts
    rst = 1'b0; tx_send = 1'b1; tx_data = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_tx", i, tx, 1'b1);
      chk("rst_busy", i, tx_busy, 1'b0);
      chk("rst_done", i, tx_done, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk("rel_busy", 0, tx_busy, 1'b0);
    chk("rel_tx", 0, tx, 1'b1);
    capture(45, 0, 8'h00, 1'b0, 1'b0, 1);
    check_frame(1, 10'b1101001010, "rel_a5");

    // Table: single-pulse sends
    foreach (vecs[v]) begin
      step(); step();
      tx_data = vecs[v].data;
      tx_send = 1'b1;
      capture(45, 0, 8'h00, 1'b0, 1'b0, 1);
      check_frame(1, vecs[v].frame, $sformatf("vec%0d", v));
      lows = 0;
      for (int l = 1; l <= 40; l++) if (tx_log[l] === 1'b0) lows++;
      chk_int($sformatf("vec%0d_lows", v), lows, vecs[v].lows);
    end

    // Data change plus a second request mid-frame are both ignored
    step(); step();
    tx_data = 8'h3C; tx_send = 1'b1;
    capture(55, 10, 8'hFF, 1'b1, 1'b1, 1);
    check_frame(1, 10'b1001111000, "latch");
    for (int l = 42; l <= 55; l++) begin
      chk("latch_idle_busy", l, busy_log[l], 1'b0);
      chk("latch_idle_tx", l, tx_log[l], 1'b1);
    end
    dones = 0;
    for (int l = 1; l <= 55; l++) if (done_log[l] === 1'b1) dones++;
    chk_int("latch_done_count", dones, 1);

    // Back-to-back with tx_send held high
    step(); step();
    tx_data = 8'h00; tx_send = 1'b1;
    capture(90, 1, 8'hFF, 1'b1, 1'b0, 60);
    check_frame(1, 10'b1000000000, "b2b_0");
    check_frame(42, 10'b1111111110, "b2b_1");
    for (int l = 83; l <= 90; l++) chk("b2b_after_busy", l, busy_log[l], 1'b0);

    // Asynchronous reset in mid-data
    step(); step();
    tx_data = 8'h00; tx_send = 1'b1;
    step();
    chk("mid_busy_l1", 1, tx_busy, 1'b1);
    tx_send = 1'b0;
    for (int l = 2; l <= 17; l++) step();
    chk("mid_pre_busy", 17, tx_busy, 1'b1);
    chk("mid_pre_tx", 17, tx, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_async_tx", 17, tx, 1'b1);
    chk("mid_async_busy", 17, tx_busy, 1'b0);
    chk("mid_async_done", 17, tx_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_hold_done", 18 + i, tx_done, 1'b0);
      chk("mid_hold_tx", 18 + i, tx, 1'b1);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_post_done", i, tx_done, 1'b0);
      chk("mid_post_busy", i, tx_busy, 1'b0);
    end
    tx_data = 8'h81; tx_send = 1'b1;
    capture(45, 0, 8'h00, 1'b0, 1'b0, 1);
    check_frame(1, 10'b1100000010, "mid_81");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the 8N1 UART: serializes one byte per request onto the `tx` pin, LSB first, framed by one start bit (0) and one stop bit (1). It sits beside the receive path inside the `uart` top level and drives the physical TX pin. It presents the same `tx_data`/`tx_send`/`tx_busy` user handshake that `uart` exposes. It also adds a one-cycle `tx_done` completion pulse for host-side sequencing.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `CLKS_PER_BIT` (localparam): `CLK_FREQ / BAUD`, integer truncation. This is 868 for the defaults. Elaboration fails if it is < 2.
- `clock`  in  1: sole clock. All logic is on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `tx_data`  in  8: byte to send. Sampled only on the accept edge.
- `tx_send`  in  1: send request, level-sensitive.
- `tx_busy`  out  1: 1 while a frame is in progress.
- `tx_done`  out  1: one-cycle pulse when a frame completes.
- `tx`  out  1: serial line. Registered output. Idles high.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Datapath:
  - 8-bit shift register holding the byte.
  - Baud counter, width `$clog2(CLKS_PER_BIT)`, counting 0..CLKS_PER_BIT-1.
  - 3-bit bit index, counting 0..7.
- **IDLE**
  - `tx`=1, `tx_busy`=0.
  - On a rising edge with `tx_send`=1: latch `tx_data`, clear the baud counter, go to START.
- **START**
  - `tx`=0 for CLKS_PER_BIT cycles.
  - At baud count CLKS_PER_BIT-1: go to DATA, bit index = 0.
- **DATA**
  - `tx` = shift register bit 0.
  - At each baud-count wrap: shift right by 1 and increment the bit index.
  - After bit index 7 completes: go to STOP.
- **STOP**
  - `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - On that same edge, `tx_done` registers to 1 for exactly one cycle.
- `tx_busy` = (state != IDLE). It is registered alongside the state.
- `tx_send` is ignored in START, DATA and STOP. The latched byte is immune to later changes on `tx_data`.
- Back-to-back: if `tx_send`=1 during the first IDLE cycle (the `tx_done` cycle), the next frame is accepted on that edge.
- Reset (`rst`=0), asynchronous and taking effect at any time including mid-frame:
  - State = IDLE; `tx`=1, `tx_busy`=0, `tx_done`=0.
  - Counters and shift register are cleared.
  - The partial frame is abandoned; no completion pulse is issued.
- After `rst` deasserts, the first possible accept is on the next rising edge.

## Timing
- Accept edge T0 (IDLE with `tx_send`=1).
- From T0+1 on, `tx_busy`=1.
- `tx` over the frame, with each bit held exactly CLKS_PER_BIT cycles:
  - start bit: T0+1 .. T0+CLKS_PER_BIT
  - data bit k (k=0..7): T0+1+(k+1)·CLKS_PER_BIT .. T0+(k+2)·CLKS_PER_BIT
  - stop bit: T0+1+9·CLKS_PER_BIT .. T0+10·CLKS_PER_BIT
- At T0+10·CLKS_PER_BIT+1:
  - state = IDLE, `tx_busy`=0.
  - `tx_done`=1 for this single cycle.
  - `tx` stays 1.
- Minimum frame-to-frame period: 10·CLKS_PER_BIT+1 cycles. The line holds 1 for one extra cycle between back-to-back stop and start bits.
- No glitches on `tx`: it changes only on clock edges, plus the asynchronous reset assertion.

## Test plan
All scenarios use CLK_FREQ=1000, BAUD=250, which gives CLKS_PER_BIT=4 and a 40-cycle frame.

1. Reset while `tx_send`=1 and `rst`=0 → `tx`=1, `tx_busy`=0, `tx_done`=0 throughout. No frame starts until after the deassert edge.
2. Send 0xA5 (pulse `tx_send` for 1 cycle) → `tx`, sampled every 4 cycles from T0+1, reads 0,1,0,1,0,0,1,0,1,1. `tx_busy` is 1 for cycles T0+1..T0+40. `tx_done` pulses at T0+41.
3. Send 0x3C, then change `tx_data` to 0xFF and pulse `tx_send` at T0+10 → the serialized frame is still 0x3C. No second frame follows. `tx_done` pulses exactly once.
4. Hold `tx_send`=1 with 0x00 then 0xFF → the two frames are separated by exactly one idle cycle (`tx`=1). The second frame's start bit begins at T0+42. `tx_done` pulses at T0+41 and T0+82.
5. Assert `rst`=0 at T0+17, in mid-data → `tx`=1 and `tx_busy`=0 within the same cycle, asynchronously. No `tx_done`. A new 0x81 sent after release produces a clean frame 0,1,0,0,0,0,0,0,1,1.
6. Send 0xFF and 0x00 (separate frames) → `tx` low only for the start bit, and low for 9 bit-times respectively. The stop bit is always high for 4 cycles.
